param_memory: RTL and testbench

PARAM_MEMORY -- requirements
Module: param_memory

---
 rtl/param_memory.sv | 146 ++++++++++++++
 tb/tb_param_memory.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// Single-port word memory with byte-lane writes, a pipelined read path of
// configurable latency, address protection, and a self-clear sequence after reset.
module param_memory #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 1024,
    parameter int RD_LAT       = 1,
    parameter int PROTECT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                wr_err,
    output logic                init_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Out-of-range addresses and (optionally) word 0 are rejected.
    function automatic logic f_addr_illegal(input logic [ADDR_W-1:0] addr);
        logic ill;
        ill = ({1'b0, addr} >= DEPTH_L);
        if ((PROTECT_ZERO != 32'sd0) && (addr == {ADDR_W{1'b0}})) begin
            ill = 1'b1;
        end
        return ill;
    endfunction

    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic              r_ready;
    logic              r_init_done;
    logic              r_wr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [RD_LAT-1:0] r_rd_vld;
    logic [RD_LAT-1:0] r_rd_err;
    logic [DATA_W-1:0] r_rd_data [RD_LAT];

    logic              w_accept;
    logic              w_illegal;
    logic              w_wr_ok;
    logic              w_rd;
    logic              w_clr_we;
    logic [IDX_W-1:0]  w_idx;

    assign w_accept  = req_valid & r_ready;
    assign w_illegal = f_addr_illegal(req_addr);
    assign w_wr_ok   = w_accept & req_we & ~w_illegal;
    assign w_rd      = w_accept & ~req_we;
    assign w_idx     = req_addr[IDX_W-1:0];
    // Clearing is held off while reset is asserted so reset alone never alters contents.
    assign w_clr_we  = (r_state == ST_INIT) & rst_n;

    // Control FSM: walk the clear counter through every word, then accept requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= {IDX_W{1'b0}};
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state     <= ST_RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + IDX_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    r_state     <= ST_RUN;
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_clr_cnt   <= {IDX_W{1'b0}};
                    r_ready     <= 1'b0;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear writes during INIT, byte-lane writes during RUN.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= {DATA_W{1'b0}};
        end else if (w_wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline and write-reject pulse; data and error stay zero in empty slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= {RD_LAT{1'b0}};
            r_rd_err <= {RD_LAT{1'b0}};
            r_wr_err <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_rd_data[s] <= {DATA_W{1'b0}};
            end
        end else begin
            r_wr_err     <= w_accept & req_we & w_illegal;
            r_rd_vld[0]  <= w_rd;
            r_rd_err[0]  <= w_rd & w_illegal;
            r_rd_data[0] <= (w_rd & ~w_illegal) ? r_mem[w_idx] : {DATA_W{1'b0}};
            for (int s = 1; s < RD_LAT; s++) begin
                r_rd_vld[s]  <= r_rd_vld[s-1];
                r_rd_err[s]  <= r_rd_err[s-1];
                r_rd_data[s] <= r_rd_data[s-1];
            end
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign wr_err    = r_wr_err;
    assign rsp_valid = r_rd_vld[RD_LAT-1];
    assign rsp_err   = r_rd_err[RD_LAT-1];
    assign rsp_data  = r_rd_data[RD_LAT-1];

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory (RD_LAT=3): reference word model plus a
// response scoreboard that checks data, error flag and arrival cycle.
module tb_param_memory;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              wr_err;
    logic              init_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [DEPTH];

    param_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .RD_LAT(RD_LAT), .PROTECT_ZERO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wr_err(wr_err), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_illegal(input logic [15:0] a);
        return (a >= 16'd1024) || (a == 16'd0);
    endfunction

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic issue(input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
        exp_t e;
        logic ill;
        ill       = is_illegal(addr);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        chk("req_ready", 32'(req_ready), 32'd1);
        if (!we) begin
            e.data = ill ? 16'h0000 : model[addr[9:0]];
            e.err  = ill;
            e.cyc  = cyc + RD_LAT;
            sb.push_back(e);
        end else if (!ill) begin
            for (int b = 0; b < 2; b++) begin
                if (be[b]) model[addr[9:0]][8*b +: 8] = wd[8*b +: 8];
            end
        end
        @(negedge clk);
        chk("wr_err", 32'(wr_err), 32'(we & ill));
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("init_len", 32'(n), 32'(DEPTH - 1));
        chk("init_done", 32'(init_done), 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            chk("idle_data", 32'(rsp_data), 32'd0);
            chk("idle_err", 32'(rsp_err), 32'd0);
            if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                chk("rsp_missing", 32'(rsp_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_be    = 2'b00;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        #2 rst_n = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'd5;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);

        // Release with a read held pending through the whole clear phase.
        rst_n = 1'b1;
        wait_init();
        issue(1'b0, 16'd5, 16'h0000, 2'b00);

        // Byte-lane merge, then read-after-write on the very next cycle.
        issue(1'b1, 16'd3, 16'hABCD, 2'b11);
        issue(1'b1, 16'd3, 16'h1234, 2'b01);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        idle();

        // Back-to-back reads with distinct contents.
        issue(1'b1, 16'd1, 16'h0011, 2'b11);
        issue(1'b1, 16'd2, 16'h0022, 2'b11);
        issue(1'b1, 16'd3, 16'h0033, 2'b11);
        issue(1'b0, 16'd1, 16'h0000, 2'b00);
        issue(1'b0, 16'd2, 16'h0000, 2'b00);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        idle();

        // Protected and out-of-range accesses.
        issue(1'b1, 16'd0,    16'hFFFF, 2'b11);
        issue(1'b1, 16'd1024, 16'hFFFF, 2'b11);
        issue(1'b1, 16'd1027, 16'hFFFF, 2'b11);
        issue(1'b0, 16'd0,    16'h0000, 2'b00);
        issue(1'b0, 16'd1024, 16'h0000, 2'b00);
        issue(1'b0, 16'd3,    16'h0000, 2'b00);
        issue(1'b0, 16'd1,    16'h0000, 2'b00);

        // Empty byte mask, last legal word, upper lane only.
        issue(1'b1, 16'd2,    16'hFFFF, 2'b00);
        issue(1'b0, 16'd2,    16'h0000, 2'b00);
        issue(1'b1, 16'd1023, 16'hBEEF, 2'b11);
        issue(1'b0, 16'd1023, 16'h0000, 2'b00);
        issue(1'b1, 16'd1,    16'h5A5A, 2'b10);
        issue(1'b0, 16'd1,    16'h0000, 2'b00);

        for (int i = 0; i < 24; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom_range(1, 15)),
                  16'($urandom), 2'($urandom_range(0, 3)));
        end
        repeat (RD_LAT + 1) idle();

        // Reset one cycle after a read is accepted: its response must never appear.
        issue(1'b1, 16'd4, 16'h5555, 2'b11);
        issue(1'b0, 16'd4, 16'h0000, 2'b00);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        wait_init();
        issue(1'b0, 16'd4,    16'h0000, 2'b00);
        issue(1'b0, 16'd3,    16'h0000, 2'b00);
        issue(1'b0, 16'd1023, 16'h0000, 2'b00);
        repeat (RD_LAT + 2) idle();
        chk("queue_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
